// File: rtl/reg_bypass_scoreboard.sv
// Operand bypass network and long-latency scoreboard for the ID stage.
// Resolves each read port from EX/MM/WB forwarding, tracks destinations of
// in-flight long-latency ops, and raises stall on load-use or busy hazards.
module reg_bypass_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int SB_DEPTH = 4,
    parameter int LAT_W    = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]           rd_addr,
    input  logic [NUM_RD*DATA_W-1:0]           rd_val_regs,
    input  logic [ADDR_W-1:0]                  ex_addr,
    input  logic [DATA_W-1:0]                  ex_val,
    input  logic [1:0]                         ex_type,
    input  logic [ADDR_W-1:0]                  mm_addr,
    input  logic [DATA_W-1:0]                  mm_val,
    input  logic [1:0]                         mm_type,
    input  logic [ADDR_W-1:0]                  wb_addr,
    input  logic [DATA_W-1:0]                  wb_val,
    input  logic                               wb_we,
    input  logic                               lr_start,
    input  logic [ADDR_W-1:0]                  lr_addr,
    input  logic [LAT_W-1:0]                   lr_lat,
    input  logic                               flush,
    output logic [NUM_RD*DATA_W-1:0]           rd_val_out,
    output logic                               stall,
    output logic                               lr_ready,
    output logic [$clog2(SB_DEPTH+1)-1:0]      sb_busy_cnt,
    output logic [15:0]                        stall_cnt
);

    // Memory access type encodings shared with the pipeline stages
    localparam logic [1:0] MEM_ACCESS_TYPE_R2R = 2'd1;
    localparam logic [1:0] MEM_ACCESS_TYPE_M2R = 2'd2;

    localparam int CNT_W = $clog2(SB_DEPTH+1);

    logic [SB_DEPTH-1:0] sb_busy;
    logic [ADDR_W-1:0]   sb_dest [SB_DEPTH];
    logic [LAT_W-1:0]    sb_cnt  [SB_DEPTH];

    logic [ADDR_W-1:0]   ra     [NUM_RD];
    logic [SB_DEPTH-1:0] alloc_oh;
    logic                alloc_found;
    logic                alloc_en;
    logic [LAT_W-1:0]    lat_eff;
    logic [NUM_RD-1:0]   port_hz;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Unpack the per-port read addresses
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            ra[p] = rd_addr[p*ADDR_W +: ADDR_W];
        end
    end

    // Forwarding mux per port: zero reg, then EX, MM, WB, register file
    always_comb begin
        rd_val_out = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ra[p] == '0)
                rd_val_out[p*DATA_W +: DATA_W] = '0;
            else if (ra[p] == ex_addr && ex_type == MEM_ACCESS_TYPE_R2R)
                rd_val_out[p*DATA_W +: DATA_W] = ex_val;
            else if (ra[p] == mm_addr &&
                     (mm_type == MEM_ACCESS_TYPE_R2R || mm_type == MEM_ACCESS_TYPE_M2R))
                rd_val_out[p*DATA_W +: DATA_W] = mm_val;
            else if (ra[p] == wb_addr && wb_we)
                rd_val_out[p*DATA_W +: DATA_W] = wb_val;
            else
                rd_val_out[p*DATA_W +: DATA_W] = rd_val_regs[p*DATA_W +: DATA_W];
        end
    end

    // Hazard detection: load-use in EX or a read of any busy destination
    always_comb begin
        port_hz = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (ra[p] != '0) begin
                if (ra[p] == ex_addr && ex_type == MEM_ACCESS_TYPE_M2R)
                    port_hz[p] = 1'b1;
                for (int e = 0; e < SB_DEPTH; e++) begin
                    if (sb_busy[e] && sb_dest[e] == ra[p])
                        port_hz[p] = 1'b1;
                end
            end
        end
        stall = |port_hz;
    end

    // Occupancy and lowest-index free entry, from registered state only
    always_comb begin
        sb_busy_cnt = '0;
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int e = 0; e < SB_DEPTH; e++) begin
            if (sb_busy[e])
                sb_busy_cnt = sb_busy_cnt + CNT_W'(1);
            else if (!alloc_found) begin
                alloc_oh[e] = 1'b1;
                alloc_found = 1'b1;
            end
        end
        lr_ready = alloc_found;
        alloc_en = lr_start && alloc_found && (lr_addr != '0) && !flush;
        lat_eff  = (lr_lat == '0) ? LAT_W'(1) : lr_lat;
    end

    // Scoreboard entries: countdown, retire on 1->0, allocate, flush clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                sb_busy[e] <= 1'b0;
                sb_dest[e] <= '0;
                sb_cnt[e]  <= '0;
            end
        end else if (flush) begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                sb_busy[e] <= 1'b0;
                sb_cnt[e]  <= '0;
            end
        end else begin
            for (int e = 0; e < SB_DEPTH; e++) begin
                if (sb_busy[e]) begin
                    sb_cnt[e] <= sb_cnt[e] - LAT_W'(1);
                    if (sb_cnt[e] == LAT_W'(1))
                        sb_busy[e] <= 1'b0;
                end else if (alloc_en && alloc_oh[e]) begin
                    sb_busy[e] <= 1'b1;
                    sb_dest[e] <= lr_addr;
                    sb_cnt[e]  <= lat_eff;
                end
            end
        end
    end

    // Saturating stall-cycle counter, untouched by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall)
            stall_cnt <= sat_inc16(stall_cnt);
    end

endmodule

// File: tb/tb_reg_bypass_scoreboard.sv
// Self-checking bench for reg_bypass_scoreboard: expected values are queued
// as stimulus is applied and compared once the outputs have settled.
module tb_reg_bypass_scoreboard;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int SB_DEPTH = 4;
    localparam int LAT_W = 4;

    localparam logic [1:0] T_NONE = 2'd0;
    localparam logic [1:0] T_R2R  = 2'd1;
    localparam logic [1:0] T_M2R  = 2'd2;
    localparam logic [1:0] T_R2M  = 2'd3;

    localparam int S_P0 = 0, S_P1 = 1, S_STALL = 2, S_RDY = 3, S_BCNT = 4, S_SCNT = 5;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [ADDR_W-1:0]        rd0 = '0, rd1 = '0;
    logic [DATA_W-1:0]        reg0 = '0, reg1 = '0;
    logic [ADDR_W-1:0]        ex_addr = '0, mm_addr = '0, wb_addr = '0;
    logic [DATA_W-1:0]        ex_val = '0, mm_val = '0, wb_val = '0;
    logic [1:0]               ex_type = T_NONE, mm_type = T_NONE;
    logic                     wb_we = 1'b0;
    logic                     lr_start = 1'b0;
    logic [ADDR_W-1:0]        lr_addr = '0;
    logic [LAT_W-1:0]         lr_lat = '0;
    logic                     flush = 1'b0;
    logic [NUM_RD*DATA_W-1:0] rd_val_out;
    logic                     stall;
    logic                     lr_ready;
    logic [2:0]               sb_busy_cnt;
    logic [15:0]              stall_cnt;

    int total = 0;
    int bad = 0;
    int exp_scnt = 0;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    exp_t exp_q[$];

    reg_bypass_scoreboard #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD),
        .SB_DEPTH(SB_DEPTH), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_addr({rd1, rd0}), .rd_val_regs({reg1, reg0}),
        .ex_addr(ex_addr), .ex_val(ex_val), .ex_type(ex_type),
        .mm_addr(mm_addr), .mm_val(mm_val), .mm_type(mm_type),
        .wb_addr(wb_addr), .wb_val(wb_val), .wb_we(wb_we),
        .lr_start(lr_start), .lr_addr(lr_addr), .lr_lat(lr_lat),
        .flush(flush),
        .rd_val_out(rd_val_out), .stall(stall), .lr_ready(lr_ready),
        .sb_busy_cnt(sb_busy_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_P0:    return rd_val_out[31:0];
            S_P1:    return rd_val_out[63:32];
            S_STALL: return {31'd0, stall};
            S_RDY:   return {31'd0, lr_ready};
            S_BCNT:  return {29'd0, sb_busy_cnt};
            default: return {16'd0, stall_cnt};
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    // Let combinational outputs settle, then compare everything queued
    task automatic drain();
        exp_t e;
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sel), e.exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge
    task automatic cyc();
        if (stall) exp_scnt = (exp_scnt == 65535) ? 65535 : exp_scnt + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [LAT_W-1:0] l);
        lr_start = 1'b1;
        lr_addr  = a;
        lr_lat   = l;
    endtask

    task automatic idle_lr();
        lr_start = 1'b0;
        lr_addr  = '0;
        lr_lat   = '0;
    endtask

    initial begin
        // Reset state
        #3;
        expect_val("rst_ready", S_RDY, 1);
        expect_val("rst_bcnt", S_BCNT, 0);
        expect_val("rst_scnt", S_SCNT, 0);
        expect_val("rst_stall", S_STALL, 0);
        drain();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Forwarding priority
        rd0 = 5; rd1 = 7; reg0 = 32'h1111; reg1 = 32'h7777;
        ex_addr = 5; ex_type = T_R2R; ex_val = 32'hAAAA;
        mm_addr = 5; mm_type = T_R2R; mm_val = 32'hBBBB;
        wb_addr = 5; wb_we = 1'b1; wb_val = 32'hCCCC;
        expect_val("pri_ex", S_P0, 32'hAAAA);
        expect_val("pri_p1_reg", S_P1, 32'h7777);
        expect_val("pri_nostall", S_STALL, 0);
        drain();
        ex_type = T_R2M;
        expect_val("pri_mm", S_P0, 32'hBBBB);
        drain();
        ex_type = T_M2R; mm_type = T_M2R;
        expect_val("pri_mm_m2r", S_P0, 32'hBBBB);
        expect_val("pri_loaduse", S_STALL, 1);
        drain();
        ex_type = T_R2R; ex_addr = 6; mm_type = T_R2M;
        expect_val("pri_wb", S_P0, 32'hCCCC);
        drain();
        wb_we = 1'b0;
        expect_val("pri_reg", S_P0, 32'h1111);
        drain();
        rd1 = 6; wb_addr = 6; wb_we = 1'b1; ex_addr = 6; ex_type = T_R2R;
        expect_val("pri_p1_ex", S_P1, 32'hAAAA);
        drain();

        // Zero register
        rd0 = 0; rd1 = 0;
        ex_addr = 0; ex_type = T_M2R; mm_addr = 0; mm_type = T_R2R;
        wb_addr = 0; wb_we = 1'b1;
        issue(0, 3);
        expect_val("zero_val", S_P0, 0);
        expect_val("zero_stall", S_STALL, 0);
        drain();
        cyc();
        idle_lr();
        ex_type = T_NONE; mm_type = T_NONE; wb_we = 1'b0;
        expect_val("zero_lr_dropped", S_BCNT, 0);
        drain();

        // Latency 3 on r8
        rd0 = 8;
        issue(8, 3);
        expect_val("lat_issue_cyc", S_STALL, 0);
        drain();
        cyc();
        idle_lr();
        for (int k = 1; k <= 3; k++) begin
            expect_val($sformatf("lat3_T+%0d", k), S_STALL, 1);
            drain();
            cyc();
        end
        expect_val("lat3_T+4", S_STALL, 0);
        drain();

        // Latency 0 behaves as 1
        issue(8, 0);
        drain();
        cyc();
        idle_lr();
        expect_val("lat0_T+1", S_STALL, 1);
        drain();
        cyc();
        expect_val("lat0_T+2", S_STALL, 0);
        expect_val("lat_scnt", S_SCNT, 4);
        drain();
        rd0 = 0;

        // Fill the scoreboard
        for (int k = 0; k < 4; k++) begin
            issue(ADDR_W'(10 + k), 5);
            cyc();
        end
        issue(14, 1);
        expect_val("full_ready", S_RDY, 0);
        expect_val("full_bcnt", S_BCNT, 4);
        drain();
        cyc();
        idle_lr();
        rd0 = 14;
        expect_val("full_still", S_RDY, 0);
        expect_val("fifth_dropped", S_STALL, 0);
        drain();
        cyc();
        expect_val("free_ready", S_RDY, 1);
        expect_val("free_bcnt", S_BCNT, 3);
        drain();
        rd0 = 0;
        repeat (4) cyc();
        expect_val("drained_bcnt", S_BCNT, 0);
        drain();

        // Flush with a concurrent issue
        issue(20, 7);
        cyc();
        issue(21, 7);
        cyc();
        issue(22, 4);
        flush = 1'b1;
        rd0 = 20;
        expect_val("pre_flush_bcnt", S_BCNT, 2);
        expect_val("flush_stall", S_STALL, 1);
        drain();
        cyc();
        flush = 1'b0;
        idle_lr();
        expect_val("post_flush_bcnt", S_BCNT, 0);
        expect_val("post_flush_r20", S_STALL, 0);
        drain();
        rd0 = 22;
        expect_val("flush_drop_r22", S_STALL, 0);
        expect_val("flush_keeps_scnt", S_SCNT, exp_scnt);
        drain();

        // Reset pulse mid-countdown
        rd0 = 8;
        issue(8, 9);
        cyc();
        idle_lr();
        cyc();
        cyc();
        expect_val("pre_rst_stall", S_STALL, 1);
        drain();
        rst_n = 1'b0;
        expect_val("async_rst_bcnt", S_BCNT, 0);
        expect_val("async_rst_ready", S_RDY, 1);
        expect_val("async_rst_stall", S_STALL, 0);
        expect_val("async_rst_scnt", S_SCNT, 0);
        drain();
        #1;
        rst_n = 1'b1;
        exp_scnt = 0;
        cyc();
        expect_val("after_rst_scnt", S_SCNT, 0);
        drain();

        // Saturation under a held load-use stall
        rd0 = 3; ex_addr = 3; ex_type = T_M2R;
        repeat (65534) cyc();
        expect_val("sat_fffe", S_SCNT, 32'hFFFE);
        drain();
        cyc();
        expect_val("sat_ffff", S_SCNT, 32'hFFFF);
        drain();
        repeat (4465) cyc();
        expect_val("sat_hold", S_SCNT, 32'hFFFF);
        expect_val("sat_stall", S_STALL, 1);
        expect_val("sat_model", S_SCNT, exp_scnt);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_bypass_scoreboard.md
REG_BYPASS_SCOREBOARD -- requirements
Module: reg_bypass_scoreboard

Interface
REQ-001 The module SHALL take parameters: DATA_W (default 32, register data width); ADDR_W (default 5, register address width); NUM_RD (default 2, number of read ports); SB_DEPTH (default 4, number of scoreboard entries); LAT_W (default 4, latency field width).
REQ-002 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low; the ports are listed below.
REQ-003 clk  in  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rd_addr  in  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-006 rd_val_regs  in  NUM_RD*DATA_W  register-file values, one per port, packed the same way.
REQ-007 ex_addr / ex_val / ex_type  in  ADDR_W / DATA_W / 2  EX-stage destination, result and access type (MEM_ACCESS_TYPE_* encodings from defs).
REQ-008 mm_addr / mm_val / mm_type  in  ADDR_W / DATA_W / 2  MM-stage destination, result and access type.
REQ-009 wb_addr / wb_val / wb_we  in  ADDR_W / DATA_W / 1  WB-stage destination, result and write enable.
REQ-010 lr_start / lr_addr / lr_lat  in  1 / ADDR_W / LAT_W  long-latency op issue, its destination, and its latency in cycles.
REQ-011 flush  in  1  pipeline flush; clears the scoreboard.
REQ-012 rd_val_out  out  NUM_RD*DATA_W  resolved operand values.
REQ-013 stall  out  1  the ID stage must hold this cycle.
REQ-014 lr_ready  out  1  at least one scoreboard entry is free.
REQ-015 sb_busy_cnt  out  clog2(SB_DEPTH+1)  number of busy entries.
REQ-016 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-017 Per port, rd_val_out SHALL be combinational, with this priority: addr==0 gives 0; addr==ex_addr with ex_type R2R gives ex_val; addr==mm_addr with mm_type R2R or M2R gives mm_val; addr==wb_addr with wb_we gives wb_val; otherwise rd_val_regs.
REQ-018 The MM match SHALL test mm_type only; ex_type SHALL have no influence on MM selection.
REQ-019 Each scoreboard entry SHALL hold: a busy bit, an ADDR_W destination, and a LAT_W down-counter.
REQ-020 On lr_start with lr_ready=1, lr_addr!=0 and flush=0, the lowest-index free entry SHALL become busy next edge with counter = max(lr_lat,1).
REQ-021 A lr_start SHALL be silently ignored when lr_ready=0, when lr_addr==0, or when flush=1.
REQ-022 Each busy entry SHALL decrement by 1 per cycle and SHALL clear its busy bit on the edge where its counter goes 1->0.
REQ-023 The destination of an entry SHALL therefore be busy for exactly max(lr_lat,1) cycles following the issue cycle.
REQ-024 lr_ready and sb_busy_cnt SHALL be derived from registered state only, so an entry freeing this edge is allocatable next cycle, not in the same cycle.
REQ-025 Duplicate destinations SHALL be permitted; the address stays hazardous until every matching entry is free.
REQ-026 stall SHALL be 1 when any port has rd_addr!=0 and either (a) rd_addr==ex_addr with ex_type M2R (load-use), or (b) rd_addr matches any busy entry.
REQ-027 stall SHALL be combinational.
REQ-028 flush=1 SHALL clear all busy bits and counters on the next edge; while flush=1, the scoreboard term of stall SHALL still reflect the current registered state.
REQ-029 stall_cnt SHALL increment on every edge where stall=1 and SHALL saturate at 16'hFFFF.
REQ-030 flush SHALL NOT clear stall_cnt.

Reset
REQ-031 While rst_n=0: all busy bits, counters and destinations SHALL be 0, with sb_busy_cnt=0, lr_ready=1 and stall_cnt=0.
REQ-032 Reset assertion mid-operation SHALL discard all pending entries immediately (asynchronously).
REQ-033 rd_val_out and stall SHALL remain purely combinational from the inputs and the cleared state while reset is asserted.

Verification
REQ-034 Priority: rd_addr0=5, ex_addr=5/R2R/val 0xAAAA, mm_addr=5/R2R/0xBBBB, wb 5/we/0xCCCC -> out 0xAAAA; set ex_type=R2M -> 0xBBBB; set mm_type=M2R, ex_type=M2R -> 0xBBBB with stall=1.
REQ-035 Zero register: rd_addr=0 with every stage matching addr 0 -> out 0 and stall=0.
REQ-036 Latency: lr_start addr 8, lr_lat 3 at cycle T -> stall=1 for reads of r8 in cycles T+1..T+3 and 0 at T+4; lr_lat=0 -> stall only at T+1.
REQ-037 Full: SB_DEPTH=4, issue 4 ops with lat 5 -> lr_ready=0 and sb_busy_cnt=4; a fifth lr_start is dropped; lr_ready returns to 1 the cycle after the first entry frees.
REQ-038 Flush and reset: flush asserted together with lr_start while 2 entries are busy -> next cycle sb_busy_cnt=0 and the new op is not allocated; rst_n pulse mid-countdown -> busy cleared immediately and stall_cnt=0.
REQ-039 Saturation: hold stall=1 for 70000 cycles -> stall_cnt=0xFFFF and no wrap-around.
